// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rr_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between two
//               requesters. The current owner keeps the RAM for up to
//               MAX_BURST consecutive grants while the other side waits.
//               Read data is returned one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

    // Arbitration state. last_owner_q resets to requester 1 so that the
    // round-robin pointer favours requester 0 first. fresh_q marks "no grant
    // since reset": while set, a contention goes to the requester after
    // last_owner (requester 0) instead of being kept by the nominal owner.
    logic       last_owner_q;
    logic [3:0] burst_cnt_q;
    logic       fresh_q;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_owner_keeps;

    // Grant decision: single requester wins outright; under contention the
    // owner keeps the RAM until its burst allowance is used up.
    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_owner_keeps = (burst_cnt_q < C_MAX_BURST) && !fresh_q;
        if (!reset) begin
            if (req0 && req1) begin
                if (w_owner_keeps) begin
                    w_gnt0 = ~last_owner_q;
                    w_gnt1 =  last_owner_q;
                end else begin
                    w_gnt0 =  last_owner_q;
                    w_gnt1 = ~last_owner_q;
                end
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // RAM port mux: granted requester's fields, zeros when idle or in reset.
    always_comb begin
        ram_waddr = '0;
        ram_raddr = '0;
        ram_wdata = '0;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;
        if (w_gnt0) begin
            ram_waddr = addr0;
            ram_raddr = addr0;
            ram_wdata = wdata0;
            ram_wr    = we0;
            ram_rd    = ~we0;
        end else if (w_gnt1) begin
            ram_waddr = addr1;
            ram_raddr = addr1;
            ram_wdata = wdata1;
            ram_wr    = we1;
            ram_rd    = ~we1;
        end
    end

    // Ownership and burst counter update; counter saturates at MAX_BURST and
    // clears on any idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            fresh_q      <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            fresh_q <= 1'b0;
            if (w_gnt1 == last_owner_q) begin
                if (burst_cnt_q < C_MAX_BURST) begin
                    burst_cnt_q <= burst_cnt_q + 4'd1;
                end
            end else begin
                last_owner_q <= w_gnt1;
                burst_cnt_q  <= 4'd1;
            end
        end else begin
            burst_cnt_q <= 4'd0;
        end
    end

    // Read return: capture RAM data for a granted read, one-cycle rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= w_gnt0 & ~we0;
            rvalid1 <= w_gnt1 & ~we1;
            if (w_gnt0 && !we0) begin
                rdata0 <= ram_rdata;
            end
            if (w_gnt1 && !we1) begin
                rdata1 <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rr_arbiter
// Description : Self-checking bench for ram_rr_arbiter: directed scenarios
//               followed by randomized held-until-granted traffic, compared
//               against a transaction-level reference model and a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rr_arbiter;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              ram_wr, ram_rd;

    always #5 clk = ~clk;

    ram_rr_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata),
        .ram_wr   (ram_wr),
        .ram_rd   (ram_rd),
        .ram_rdata(ram_rdata)
    );

    // RAM model: combinational read, write at the clock edge.
    logic [DATA_W-1:0] ram_mem [32];
    assign ram_rdata = ram_rd ? ram_mem[ram_raddr] : '0;
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_waddr] <= ram_wdata;
    end

    // Reference model state (transaction level).
    int                n_checks = 0;
    int                n_err    = 0;
    int                owner;       // requester that received the last grant
    int                streak;      // consecutive grants to owner, 0 after idle
    bit                fresh;       // no grant yet since reset
    logic              ev0, ev1;
    logic [DATA_W-1:0] ed0, ed1;
    logic [DATA_W-1:0] exp_mem [32];
    int                dut_g;       // grant observed in the last cycle (-1 none)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge,
    // advance the model, return 1 time unit after the rising edge.
    task automatic cycle();
        int                g;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ew;
        logic              ewe;
        @(negedge clk);
        if (reset)              g = -1;
        else if (req0 && req1)  g = fresh ? 0 : ((streak < MAX_BURST) ? owner : 1 - owner);
        else if (req0)          g = 0;
        else if (req1)          g = 1;
        else                    g = -1;
        ea  = (g == 0) ? addr0  : (g == 1) ? addr1  : '0;
        ew  = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
        ewe = (g == 0) ? we0    : we1;
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("ram_wr", 32'(ram_wr), 32'(g >= 0 && ewe));
        chk("ram_rd", 32'(ram_rd), 32'(g >= 0 && !ewe));
        chk("ram_waddr", 32'(ram_waddr), 32'(ea));
        chk("ram_raddr", 32'(ram_raddr), 32'(ea));
        chk("ram_wdata", 32'(ram_wdata), 32'(ew));
        chk("rvalid0", 32'(rvalid0), 32'(ev0));
        chk("rvalid1", 32'(rvalid1), 32'(ev1));
        chk("rdata0", 32'(rdata0), 32'(ed0));
        chk("rdata1", 32'(rdata1), 32'(ed1));
        dut_g = gnt0 ? 0 : (gnt1 ? 1 : -1);
        if (reset) begin
            fresh = 1; owner = 1; streak = 0;
            ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
        end else begin
            ev0 = 0; ev1 = 0;
            if (g >= 0) begin
                if (g == owner) streak++;
                else begin owner = g; streak = 1; end
                fresh = 0;
                if (ewe) exp_mem[ea] = ew;
                else if (g == 0) begin ev0 = 1; ed0 = exp_mem[ea]; end
                else begin ev1 = 1; ed1 = exp_mem[ea]; end
            end else begin
                streak = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int exp_seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int exp_idle [5] = '{0, 0, 0, 0, 1};

    initial begin
        for (int i = 0; i < 32; i++) begin ram_mem[i] = '0; exp_mem[i] = '0; end
        fresh = 1; owner = 1; streak = 0;
        ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0; dut_g = -1;
        reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset hold with both requesting.
        repeat (3) cycle();
        reset = 0; req0 = 0; req1 = 0;
        cycle();

        // Single write then read of address 5 by requester 0.
        req0 = 1; we0 = 1; addr0 = 5'd5; wdata0 = 16'hA5A5;
        cycle();
        chk("rw_gnt0_wr", 32'(dut_g), 32'd0);
        we0 = 0;
        cycle();
        chk("rw_gnt0_rd", 32'(dut_g), 32'd0);
        chk("rw_rvalid0", 32'(rvalid0), 32'd1);
        chk("rw_rdata0", 32'(rdata0), 32'h0000A5A5);
        chk("rw_rvalid1", 32'(rvalid1), 32'd0);
        req0 = 0;
        cycle();

        // Boundary addresses 0 and 31 via requester 1.
        req1 = 1; we1 = 1; addr1 = 5'd31; wdata1 = 16'hFFFF; cycle();
        addr1 = 5'd0; wdata1 = 16'h1234; cycle();
        we1 = 0; addr1 = 5'd31; cycle();
        chk("a31_rdata1", 32'(rdata1), 32'h0000FFFF);
        addr1 = 5'd0; cycle();
        chk("a0_rdata1", 32'(rdata1), 32'h00001234);
        req1 = 0; cycle();

        // Contention straight after reset: 0 first, bursts of MAX_BURST.
        reset = 1; cycle(); reset = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 5'd5; addr1 = 5'd31;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("contend_seq", 32'(dut_g), 32'(exp_seq[i]));
        end
        req0 = 0; req1 = 0; cycle();

        // Burst saturation without contention, then requester 0 joins.
        req1 = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("solo1_gnt", 32'(dut_g), 32'd1);
        end
        req0 = 1;
        cycle();
        chk("sat_switch", 32'(dut_g), 32'd0);
        req0 = 0; req1 = 0; cycle();

        // Idle cycle clears the burst count; owner 0 then keeps a full burst.
        req0 = 1; cycle(); cycle();
        req0 = 0; cycle();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_seq", 32'(dut_g), 32'(exp_idle[i]));
        end
        req0 = 0; req1 = 0; cycle();

        // Reset while a read return is pending.
        req1 = 1; we1 = 1; addr1 = 5'd3; wdata1 = 16'h3C3C; cycle();
        we1 = 0; cycle();
        chk("mid_rvalid1_pre", 32'(rvalid1), 32'd1);
        req1 = 0; reset = 1; cycle();
        chk("mid_rvalid1", 32'(rvalid1), 32'd0);
        chk("mid_rdata1", 32'(rdata1), 32'd0);
        reset = 0; req0 = 1; req1 = 1; cycle();
        chk("mid_first_contend", 32'(dut_g), 32'd0);
        req0 = 0; req1 = 0; cycle();

        // Randomized held-until-granted traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = $urandom_range(0, 1) == 1;
                addr0 = ADDR_W'($urandom_range(0, 7)); wdata0 = DATA_W'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = $urandom_range(0, 1) == 1;
                addr1 = ADDR_W'($urandom_range(0, 7)); wdata1 = DATA_W'($urandom);
            end
            reset = ($urandom_range(0, 40) == 0);
            cycle();
            if (dut_g == 0) begin
                req0 = $urandom_range(0, 1) == 1; we0 = $urandom_range(0, 1) == 1;
                addr0 = ADDR_W'($urandom_range(0, 7)); wdata0 = DATA_W'($urandom);
            end
            if (dut_g == 1) begin
                req1 = $urandom_range(0, 1) == 1; we1 = $urandom_range(0, 1) == 1;
                addr1 = ADDR_W'($urandom_range(0, 7)); wdata1 = DATA_W'($urandom);
            end
        end
        reset = 0; req0 = 0; req1 = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
